// File: rtl/apb_spi_master_fifo.sv
// apb_spi_master_fifo: APB slave driving a FIFO-buffered SPI master with burst transfers and sticky flags.
module apb_spi_master_fifo #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int N_SS       = 4,
    parameter int DIV_W      = 8
) (
    input  logic            i_PCLK,
    input  logic            i_PRESET,
    input  logic            i_PSEL,
    input  logic            i_PENABLE,
    input  logic            i_PWRITE,
    input  logic [15:0]     i_PADDR,
    input  logic [15:0]     i_PWDATA,
    input  logic [9:0]      i_BASE_ADDR,
    output logic [15:0]     o_PRDATA,
    output logic            o_PREADY,
    output logic            o_PSLVERR,
    output logic            o_SCLK,
    output logic            o_MOSI,
    input  logic            i_MISO,
    output logic [N_SS-1:0] o_SS_n,
    output logic            o_IRQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = $clog2(2 * DW + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD} state_t;

    state_t            state;
    logic [7:0]        cfg, status;
    logic [DIV_W-1:0]  div, cnt;
    logic [EW-1:0]     edges;
    logic [DW-1:0]     txs, rxs, txs_sh, rx_nx, tx_data;
    logic [DW:0]       rx_l, rx_m;
    logic [DW-1:0]     tx_mem [FIFO_DEPTH];
    logic [DW-1:0]     rx_mem [FIFO_DEPTH];
    logic [AW:0]       tx_wp, tx_rp, rx_wp, rx_rp;
    logic [N_SS-1:0]   ss_sel;
    logic [3:0]        idx;
    logic              done, ovr, err, sclk, mosi;
    logic              acc, wr, rd, busy, tx_empty, tx_full, rx_empty, rx_full;
    logic              flush, start, clr, tx_avail, tx_pop, tx_push, tx_push_err;
    logic              rx_pop, rx_pop_err, rx_push, ovr_set, cfg_err, done_set;
    logic              half, sample, last;
    logic              unused;

    function automatic logic fb(input logic [DW-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DW-1];
    endfunction

    assign unused      = ^{i_PADDR[1:0], i_PWDATA};
    assign acc         = i_PSEL & i_PENABLE & (i_PADDR[15:6] == i_BASE_ADDR);
    assign idx         = i_PADDR[5:2];
    assign wr          = acc & i_PWRITE;
    assign rd          = acc & ~i_PWRITE;
    assign busy        = state != IDLE;
    assign tx_empty    = tx_wp == tx_rp;
    assign tx_full     = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_empty    = rx_wp == rx_rp;
    assign rx_full     = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign flush       = wr && idx == 4'd3 && i_PWDATA[0];
    assign start       = wr && idx == 4'd3 && i_PWDATA[1];
    assign clr         = wr && idx == 4'd3 && i_PWDATA[2];
    // A flush in the same cycle as a pop wins, so the burst ends after the current word
    assign tx_avail    = !tx_empty && !flush;
    assign tx_pop      = tx_avail && ((state == IDLE && start) || state == NEXT);
    assign tx_push     = wr && idx == 4'd1 && (!tx_full || tx_pop);
    assign tx_push_err = wr && idx == 4'd1 && tx_full && !tx_pop;
    assign rx_pop      = rd && idx == 4'd1 && !rx_empty;
    assign rx_pop_err  = rd && idx == 4'd1 && rx_empty;
    assign rx_push     = state == NEXT && !rx_full && !flush;
    assign ovr_set     = state == NEXT && rx_full;
    assign cfg_err     = wr && (idx == 4'd0 || idx == 4'd2) && busy;
    assign half        = cnt == div;
    assign done_set    = (state == IDLE && start && !tx_avail) || (state == HOLD && half);
    assign sample      = !edges[0] ^ cfg[0];
    assign last        = edges == EW'(2 * DW - 1);
    assign tx_data     = tx_mem[tx_rp[AW-1:0]];
    assign txs_sh      = cfg[6] ? txs >> 1 : txs << 1;
    assign rx_l        = {i_MISO, rxs};
    assign rx_m        = {rxs, i_MISO};
    assign rx_nx       = cfg[6] ? rx_l[DW:1] : rx_m[DW-1:0];
    assign ss_sel      = ~(N_SS'(1) << (32'(cfg[5:2]) % N_SS));
    assign status      = {err, ovr, done, rx_empty, rx_full, tx_empty, tx_full, busy};

    assign o_PREADY  = 1'b1;
    assign o_PSLVERR = tx_push_err | rx_pop_err;
    assign o_PRDATA  = !rd            ? 16'h0 :
                       idx == 4'd0    ? {8'h0, status} :
                       idx == 4'd1    ? (rx_empty ? 16'h0 : 16'(rx_mem[rx_rp[AW-1:0]])) :
                       idx == 4'd2    ? 16'(div) : 16'h0;
    assign o_SCLK    = sclk;
    assign o_MOSI    = mosi;
    assign o_IRQ     = done & cfg[7];

    always_ff @(posedge i_PCLK) begin
        if (tx_push)
            tx_mem[tx_wp[AW-1:0]] <= i_PWDATA[DW-1:0];
        if (rx_push)
            rx_mem[rx_wp[AW-1:0]] <= rxs;
    end

    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            cfg   <= '0;
            div   <= '0;
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            done  <= 1'b0;
            ovr   <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (wr && idx == 4'd0 && !busy)
                cfg <= i_PWDATA[7:0];
            if (wr && idx == 4'd2 && !busy)
                div <= i_PWDATA[DIV_W-1:0];
            if (flush) begin
                tx_rp <= tx_wp;
                rx_rp <= rx_wp;
            end else begin
                tx_wp <= tx_wp + (AW+1)'(tx_push);
                tx_rp <= tx_rp + (AW+1)'(tx_pop);
                rx_wp <= rx_wp + (AW+1)'(rx_push);
                rx_rp <= rx_rp + (AW+1)'(rx_pop);
            end
            done <= done_set | (done & ~clr);
            ovr  <= ovr_set | (ovr & ~clr);
            err  <= tx_push_err | rx_pop_err | cfg_err | (err & ~clr);
        end
    end

    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            state <= IDLE;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
            ss_n_reset();
            cnt   <= '0;
            edges <= '0;
            txs   <= '0;
            rxs   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sclk  <= cfg[1];
                    cnt   <= '0;
                    edges <= '0;
                    if (start && tx_avail) begin
                        state  <= SETUP;
                        o_SS_n <= ss_sel;
                        txs    <= tx_data;
                        if (!cfg[0])
                            mosi <= fb(tx_data, cfg[6]);
                    end
                end
                SETUP: begin
                    cnt <= half ? '0 : cnt + DIV_W'(1);
                    if (half)
                        state <= SHIFT;
                end
                SHIFT: begin
                    cnt <= half ? '0 : cnt + DIV_W'(1);
                    if (half) begin
                        sclk  <= ~sclk;
                        edges <= edges + EW'(1);
                        if (sample)
                            rxs <= rx_nx;
                        else begin
                            txs  <= txs_sh;
                            mosi <= cfg[0] ? fb(txs, cfg[6]) : fb(txs_sh, cfg[6]);
                        end
                        if (last)
                            state <= NEXT;
                    end
                end
                NEXT: begin
                    cnt   <= '0;
                    edges <= '0;
                    if (tx_avail) begin
                        state <= SHIFT;
                        txs   <= tx_data;
                        if (!cfg[0])
                            mosi <= fb(tx_data, cfg[6]);
                    end else
                        state <= HOLD;
                end
                HOLD: begin
                    cnt <= cnt + DIV_W'(1);
                    if (half) begin
                        o_SS_n <= '1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    task automatic ss_n_reset();
        o_SS_n <= '1;
    endtask
endmodule

// File: tb/tb_apb_spi_master_fifo.sv
// tb_apb_spi_master_fifo: directed APB/SPI checks with MISO looped back to MOSI.
module tb_apb_spi_master_fifo;
    localparam logic [9:0] BASE = 10'h2A;

    logic        clk = 1'b0, rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [15:0] paddr = '0, pwdata = '0;
    logic [15:0] prdata;
    logic        pready, pslverr, sclk, mosi, irq;
    logic [3:0]  ss_n;
    logic        ss_idle;
    logic        mcpol = 1'b0, mcpha = 1'b0;
    logic [63:0] mon = '0;
    logic [3:0]  ss_val = 4'hF;
    int          mon_n = 0, edge_n = 0, ss_starts = 0, cyc = 0, t_prev = 0, t_last = 0;
    int          n_chk = 0, n_err = 0;

    apb_spi_master_fifo dut (
        .i_PCLK(clk), .i_PRESET(rst), .i_PSEL(psel), .i_PENABLE(penable), .i_PWRITE(pwrite),
        .i_PADDR(paddr), .i_PWDATA(pwdata), .i_BASE_ADDR(BASE), .o_PRDATA(prdata),
        .o_PREADY(pready), .o_PSLVERR(pslverr), .o_SCLK(sclk), .o_MOSI(mosi),
        .i_MISO(mosi), .o_SS_n(ss_n), .o_IRQ(irq)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc++;
    assign ss_idle = &ss_n;

    always @(sclk)
        if (!ss_idle && !rst) begin
            edge_n++;
            if ((sclk != mcpol) ^ mcpha) begin
                mon = {mon[62:0], mosi};
                mon_n++;
                t_prev = t_last;
                t_last = cyc;
            end
        end

    always @(negedge ss_idle) begin
        ss_starts++;
        ss_val = ss_n;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apb(input logic w, input logic [15:0] a, input logic [15:0] wd,
                       output logic [15:0] r, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        #1;
        r = prdata;
        e = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [15:0] wd, output logic e);
        logic [15:0] r;
        apb(1'b1, {BASE, idx, 2'b00}, wd, r, e);
    endtask

    task automatic rd(input logic [3:0] idx, output logic [15:0] r, output logic e);
        apb(1'b0, {BASE, idx, 2'b00}, 16'h0, r, e);
    endtask

    task automatic wait_idle();
        logic [15:0] s;
        logic        e;
        s = 16'h1;
        for (int i = 0; i < 500 && s[0]; i++)
            rd(4'd0, s, e);
        chk("idle_timeout", 32'(s[0]), 0);
    endtask

    logic [15:0] d;
    logic        e;
    int          bm, bs, be;
    logic [7:0]  mcfg [3]  = '{8'h01, 8'h02, 8'h43};
    logic [7:0]  mtx  [3]  = '{8'hA5, 8'hA5, 8'h0F};
    logic [7:0]  mwire[3]  = '{8'hA5, 8'hA5, 8'hF0};
    logic [7:0]  brst [4]  = '{8'h01, 8'h23, 8'h45, 8'h67};
    logic [7:0]  ovw  [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ss", 32'(ss_n), 32'hF);
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_pready", 32'(pready), 1);
        rst = 1'b0;
        rd(4'd0, d, e);
        chk("rst_status", 32'(d), 32'h14);

        // single word, mode 0, slave 3, IE
        wr(4'd2, 16'h0, e);
        wr(4'd0, 16'h8C, e);
        wr(4'd1, 16'h55, e);
        chk("push_err", 32'(e), 0);
        rd(4'd0, d, e);
        chk("st_txload", 32'(d), 32'h10);
        bm = mon_n; bs = ss_starts;
        wr(4'd3, 16'h2, e);
        wait_idle();
        chk("sw_ss", 32'(ss_val), 32'h7);
        chk("sw_starts", 32'(ss_starts - bs), 1);
        chk("sw_bits", 32'(mon_n - bm), 8);
        chk("sw_wire", 32'(mon[7:0]), 32'h55);
        chk("sw_period", 32'(t_last - t_prev), 2);
        chk("sw_ss_end", 32'(ss_n), 32'hF);
        rd(4'd0, d, e);
        chk("sw_status", 32'(d), 32'h24);
        chk("sw_irq", 32'(irq), 1);
        rd(4'd1, d, e);
        chk("sw_rx", 32'(d), 32'h55);
        chk("sw_rx_err", 32'(e), 0);
        chk("prdata_idle", 32'(prdata), 0);
        wr(4'd3, 16'h4, e);
        chk("irq_clr", 32'(irq), 0);

        // burst of four plus overflowing fifth push
        wr(4'd0, 16'h00, e);
        for (int i = 0; i < 4; i++) wr(4'd1, 16'(brst[i]), e);
        wr(4'd1, 16'h89, e);
        chk("push_full_err", 32'(e), 1);
        rd(4'd0, d, e);
        chk("st_full", 32'(d), 32'h92);
        wr(4'd3, 16'h4, e);
        bm = mon_n; bs = ss_starts;
        wr(4'd3, 16'h2, e);
        wait_idle();
        chk("b_starts", 32'(ss_starts - bs), 1);
        chk("b_ss", 32'(ss_val), 32'hE);
        chk("b_bits", 32'(mon_n - bm), 32);
        chk("b_wire", mon[31:0], 32'h01234567);
        rd(4'd0, d, e);
        chk("b_status", 32'(d), 32'h2C);
        for (int i = 0; i < 4; i++) begin
            rd(4'd1, d, e);
            chk("b_rx", 32'(d), 32'(brst[i]));
        end
        wr(4'd3, 16'h4, e);

        // modes 1..3 at DIV=3
        wr(4'd2, 16'h3, e);
        rd(4'd2, d, e);
        chk("div_rd", 32'(d), 3);
        for (int m = 0; m < 3; m++) begin
            wr(4'd0, 16'(mcfg[m]), e);
            mcpol = mcfg[m][1]; mcpha = mcfg[m][0];
            repeat (2) @(negedge clk);
            chk("m_idle_pre", 32'(sclk), 32'(mcpol));
            wr(4'd1, 16'(mtx[m]), e);
            bm = mon_n;
            wr(4'd3, 16'h2, e);
            wait_idle();
            chk("m_bits", 32'(mon_n - bm), 8);
            chk("m_wire", 32'(mon[7:0]), 32'(mwire[m]));
            chk("m_period", 32'(t_last - t_prev), 8);
            chk("m_idle_post", 32'(sclk), 32'(mcpol));
            rd(4'd1, d, e);
            chk("m_rx", 32'(d), 32'(mtx[m]));
            wr(4'd3, 16'h4, e);
        end

        // overrun: fifth word pushed mid-burst, no RX pops
        wr(4'd0, 16'h00, e);
        mcpol = 1'b0; mcpha = 1'b0;
        for (int i = 0; i < 4; i++) wr(4'd1, 16'(ovw[i]), e);
        bm = mon_n; bs = ss_starts;
        wr(4'd3, 16'h2, e);
        wr(4'd1, 16'h55, e);
        chk("ov_push_err", 32'(e), 0);
        wait_idle();
        chk("ov_bits", 32'(mon_n - bm), 40);
        chk("ov_wire", mon[31:0], 32'h22334455);
        chk("ov_starts", 32'(ss_starts - bs), 1);
        rd(4'd0, d, e);
        chk("ov_status", 32'(d), 32'h6C);
        for (int i = 0; i < 4; i++) begin
            rd(4'd1, d, e);
            chk("ov_rx", 32'(d), 32'(ovw[i]));
        end
        rd(4'd1, d, e);
        chk("empty_rd", 32'(d), 0);
        chk("empty_rd_err", 32'(e), 1);
        rd(4'd0, d, e);
        chk("ov_status2", 32'(d), 32'hF4);

        // guards: CONFIG/DIV writes while busy
        wr(4'd3, 16'h4, e);
        wr(4'd1, 16'h3C, e);
        wr(4'd3, 16'h2, e);
        wr(4'd0, 16'h03, e);
        chk("busy_cfg_err", 32'(e), 0);
        wr(4'd2, 16'h0, e);
        wait_idle();
        rd(4'd0, d, e);
        chk("g_status", 32'(d), 32'hA4);
        rd(4'd2, d, e);
        chk("g_div", 32'(d), 3);
        chk("g_sclk", 32'(sclk), 0);
        rd(4'd1, d, e);
        chk("g_rx", 32'(d), 32'h3C);
        wr(4'd3, 16'h4, e);
        bs = ss_starts;
        wr(4'd3, 16'h2, e);
        rd(4'd0, d, e);
        chk("empty_start_st", 32'(d), 32'h34);
        chk("empty_start_ss", 32'(ss_starts - bs), 0);
        wr(4'd3, 16'h4, e);
        wr(4'd1, 16'h01, e);
        wr(4'd1, 16'h02, e);
        rd(4'd0, d, e);
        chk("pre_flush", 32'(d), 32'h10);
        wr(4'd3, 16'h1, e);
        rd(4'd0, d, e);
        chk("post_flush", 32'(d), 32'h14);
        wr(4'd5, 16'hFFFF, e);
        chk("unmap_wr_err", 32'(e), 0);
        rd(4'd5, d, e);
        chk("unmap_rd", {16'(d), 15'h0, e}, 0);
        apb(1'b0, {BASE + 10'd1, 4'd0, 2'b00}, 16'h0, d, e);
        chk("other_base", {16'(d), 15'h0, e}, 0);

        // reset mid-word
        wr(4'd1, 16'hAA, e);
        be = edge_n;
        wr(4'd3, 16'h2, e);
        for (int i = 0; i < 300 && edge_n - be < 3; i++) @(negedge clk);
        chk("mid_edges", 32'(edge_n - be >= 3), 1);
        chk("mid_active", 32'(ss_n), 32'hE);
        rst = 1'b1;
        #1;
        chk("mr_ss", 32'(ss_n), 32'hF);
        chk("mr_sclk", 32'(sclk), 0);
        chk("mr_mosi", 32'(mosi), 0);
        chk("mr_irq", 32'(irq), 0);
        chk("mr_prd", {16'(prdata), 15'h0, pslverr}, 0);
        @(negedge clk);
        rst = 1'b0;
        rd(4'd0, d, e);
        chk("mr_status", 32'(d), 32'h14);
        rd(4'd2, d, e);
        chk("mr_div", 32'(d), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
